aes_round_pipe: RTL
===================

// Module: aes_round_pipe
// PURPOSE
// - Parametrised AES encryption round: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
// - Uses valid/ready handshakes on both sides and carries a sideband tag per transaction.
// - Key is captured with the state, so the upstream key scheduler need not hold it.
// - Sits between the round-key scheduler and the next round or ciphertext sink in unrolled AES cores.
// PARAMETERS
// - PIPE_STAGES  2  register stages, legal values 1 or 2:
//   - 1: a single register after AddRoundKey.
//   - 2: an additional register after ShiftRows.
// - TAG_W        8  width of the opaque sideband tag carried alongside each block (>=1).
// PORTS
// - clk        in   1                clock
// - rst        in   1                reset; asynchronous, active-high
// - in_valid   in   1                input transaction valid
// - in_ready   out  1                block accepts the input this cycle
// - in_state   in   [3:0][3:0][7:0]  state[row][col]; FIPS byte b[r+4c] maps to [r][c]
// - in_key     in   [3:0][3:0][7:0]  round key, same layout
// - in_final   in   1                final round: skip MixColumns
// - in_tag     in   TAG_W            sideband tag
// - out_valid  out  1                output transaction valid
// - out_ready  in   1                downstream accepts the output
// - out_state  out  [3:0][3:0][7:0]  round result
// - out_tag    out  TAG_W            tag of the same transaction
// BEHAVIOUR
// - Transfer rule: a transfer occurs on a rising clk edge when valid && ready.
// - Reset: while rst=1, every stage valid clears, so out_valid=0.
//   - out_state, out_tag and all data registers reset to 0.
//   - in_ready=1 one cycle after rst deasserts.
// - Reset mid-operation: in-flight blocks are discarded. No output appears for them after reset.
// - Stage valid bits: each stage s has a valid bit v[s]. Stage s advances when !v[s] or the next stage takes its data.
//   - The last stage's "take" is out_ready.
//   - in_ready = !v[0] || advance[0].
//   - in_ready is combinational from out_ready through the valid chain; there are no bubbles.
// - Throughput and latency: one block per cycle while out_ready=1.
//   - Accept-to-out_valid latency is PIPE_STAGES cycles.
// - PIPE_STAGES=2:
//   - Stage 0 registers ShiftRows(SubBytes(in_state)), in_key, in_final and in_tag.
//   - Stage 1 registers AddRoundKey(final ? s0 : MixColumns(s0), key_s0) and the tag.
// - PIPE_STAGES=1: stage 0 registers the full round result and the tag.
// - Stall behaviour: while out_valid=1 and out_ready=0, out_state and out_tag hold stable.
//   - A full pipeline deasserts in_ready in that cycle.
// - Simultaneous events (full pipeline, out_ready=1 and in_valid=1 in the same cycle):
//   - The output is consumed, the pipeline shifts, and the input is accepted.
// - Key and mode sampling: in_key and in_final are sampled only on an input transfer.
//   - Later changes to them do not affect in-flight blocks.
// - Ordering: strictly in order. No reordering and no drop.
//   - A protocol violation (in_valid dropped without a transfer) needs no special handling.
// - Arithmetic:
//   - SubBytes uses the AES S-box.
//   - MixColumns works in GF(2^8) with polynomial 0x11B.
//   - AddRoundKey is a bitwise XOR.
//   - The existing sub_bytes, shift_rows, mix_columns and add_round_key submodules are reused.
// CONFIGURATION
// - AES_ROUND_FINAL_EN defined:
//   - in_final is honoured per transaction.
//   - in_final=1 bypasses MixColumns for that block only.
// - AES_ROUND_FINAL_EN undefined:
//   - in_final is ignored and MixColumns is always applied.
//   - The final flag is not stored and no bypass mux is built.
// TESTING
// - Round 1 (FIPS-197 App. B), standard round:
//   - Stimulus: state 193de3bea0f4e22b9ac68d2ae9f84808, key a0fafe1788542cb123a339392a6c7605.
//   - Required response: out_state a49c7ff2689f352b6b5bea43026a5049 after PIPE_STAGES cycles, tag preserved.
// - Round 10, in_final=1, AES_ROUND_FINAL_EN defined:
//   - Stimulus: state eb40f21e592e38848ba113e71bc342d2, key d014f9a8c9ee2589e13f0cc8b6630ca6.
//   - Required response: out_state 3925841d02dc09fbdc118597196a0b32.
//   - With the macro undefined, the same stimulus must produce the MixColumns result, not this value.
// - Back-to-back streaming:
//   - Stimulus: 16 blocks, tags 0..15, out_ready=1.
//   - Required response: in_ready stays 1 and out_valid holds for 16 consecutive cycles with tags 0..15 in order.
// - Backpressure:
//   - Stimulus: hold out_ready=0 for 5 cycles while streaming.
//   - Required response: in_ready=0 once PIPE_STAGES blocks are held, out_state/out_tag stable, no loss or duplication after release.
// - Key change after accept:
//   - Stimulus: change in_key in the cycle after the transfer.
//   - Required response: the output still matches the key sampled at transfer.
// - Reset mid-flight:
//   - Stimulus: assert rst asynchronously with 2 blocks in flight.
//   - Required response: out_valid=0 immediately, out_state=0, and the aborted blocks never appear after deassertion.

Source files
------------

// File: rtl/aes_round_pipe.sv
// aes_round_pipe: one AES encryption round (SubBytes, ShiftRows, MixColumns, AddRoundKey) with valid/ready.
// Optional feature macro AES_ROUND_FINAL_EN: when defined, in_final bypasses MixColumns per block.

module sub_bytes (
   input  logic [3:0][3:0][7:0] state_i,
   output logic [3:0][3:0][7:0] state_o
);
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   always_comb begin
      state_o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            state_o[r][c] = SBOX[state_i[r][c]];
         end
      end
   end
endmodule

module shift_rows (
   input  logic [3:0][3:0][7:0] state_i,
   output logic [3:0][3:0][7:0] state_o
);
   // Row r rotates left by r columns.
   always_comb begin
      state_o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            state_o[r][c] = state_i[r][(c + r) % 4];
         end
      end
   end
endmodule

module mix_columns (
   input  logic [3:0][3:0][7:0] state_i,
   output logic [3:0][3:0][7:0] state_o
);
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   always_comb begin
      state_o = '0;
      for (int c = 0; c < 4; c++) begin
         state_o[0][c] = xtime(state_i[0][c]) ^ xtime(state_i[1][c]) ^ state_i[1][c]
                       ^ state_i[2][c] ^ state_i[3][c];
         state_o[1][c] = state_i[0][c] ^ xtime(state_i[1][c]) ^ xtime(state_i[2][c])
                       ^ state_i[2][c] ^ state_i[3][c];
         state_o[2][c] = state_i[0][c] ^ state_i[1][c] ^ xtime(state_i[2][c])
                       ^ xtime(state_i[3][c]) ^ state_i[3][c];
         state_o[3][c] = xtime(state_i[0][c]) ^ state_i[0][c] ^ state_i[1][c]
                       ^ state_i[2][c] ^ xtime(state_i[3][c]);
      end
   end
endmodule

module add_round_key (
   input  logic [3:0][3:0][7:0] state_i,
   input  logic [3:0][3:0][7:0] key_i,
   output logic [3:0][3:0][7:0] state_o
);
   assign state_o = state_i ^ key_i;
endmodule

module aes_round_pipe #(
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [3:0][3:0][7:0]      in_state,
   input  logic [3:0][3:0][7:0]      in_key,
   input  logic                      in_final,
   input  logic [TAG_W-1:0]          in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [3:0][3:0][7:0]      out_state,
   output logic [TAG_W-1:0]          out_tag
);
   logic [3:0][3:0][7:0] sb_state, sr_state;
   logic [3:0][3:0][7:0] mc_src, mc_state, ark_src, key_src, out_state_d;
   logic [TAG_W-1:0]     tag_src;
   logic                 v_src;
   logic                 adv_last;

   logic                 out_valid_q;
   logic [3:0][3:0][7:0] out_state_q;
   logic [TAG_W-1:0]     out_tag_q;

`ifdef AES_ROUND_FINAL_EN
   logic                 final_src;
`else
   logic                 unused_final;
   assign unused_final = in_final;
`endif

   sub_bytes  u_sub_bytes  (.state_i(in_state), .state_o(sb_state));
   shift_rows u_shift_rows (.state_i(sb_state), .state_o(sr_state));

   // The output register frees up when empty or when downstream takes it this cycle.
   assign adv_last = !out_valid_q || out_ready;

   generate
      if (PIPE_STAGES == 2) begin : g_two
         logic                 v0_q;
         logic [3:0][3:0][7:0] s0_state_q, s0_key_q;
         logic [TAG_W-1:0]     s0_tag_q;
`ifdef AES_ROUND_FINAL_EN
         logic                 s0_final_q;
`endif

         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v0_q       <= 1'b0;
               s0_state_q <= '0;
               s0_key_q   <= '0;
               s0_tag_q   <= '0;
`ifdef AES_ROUND_FINAL_EN
               s0_final_q <= 1'b0;
`endif
            end else if (in_ready) begin
               v0_q <= in_valid;
               if (in_valid) begin
                  s0_state_q <= sr_state;
                  s0_key_q   <= in_key;
                  s0_tag_q   <= in_tag;
`ifdef AES_ROUND_FINAL_EN
                  s0_final_q <= in_final;
`endif
               end
            end
         end

         assign in_ready = !v0_q || adv_last;
         assign v_src    = v0_q;
         assign mc_src   = s0_state_q;
         assign key_src  = s0_key_q;
         assign tag_src  = s0_tag_q;
`ifdef AES_ROUND_FINAL_EN
         assign final_src = s0_final_q;
`endif
      end else begin : g_one
         assign in_ready = adv_last;
         assign v_src    = in_valid;
         assign mc_src   = sr_state;
         assign key_src  = in_key;
         assign tag_src  = in_tag;
`ifdef AES_ROUND_FINAL_EN
         assign final_src = in_final;
`endif
      end
   endgenerate

   mix_columns u_mix_columns (.state_i(mc_src), .state_o(mc_state));

`ifdef AES_ROUND_FINAL_EN
   assign ark_src = final_src ? mc_src : mc_state;
`else
   assign ark_src = mc_state;
`endif

   add_round_key u_add_round_key (.state_i(ark_src), .key_i(key_src), .state_o(out_state_d));

   // NOTE: data registers are reset too, so out_state/out_tag read 0 after reset instead of stale blocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_state_q <= '0;
         out_tag_q   <= '0;
      end else if (adv_last) begin
         out_valid_q <= v_src;
         if (v_src) begin
            out_state_q <= out_state_d;
            out_tag_q   <= tag_src;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_state = out_state_q;
   assign out_tag   = out_tag_q;
endmodule
